dmem_responder: RTL and testbench

Data-memory responder for the RV32I single-cycle core: the target side of the core's `dmem_*` load/store interface. It decodes each word access into either a synchronous-write RAM or a small MMIO block. The MMIO block holds a GPIO register, a free-running cycle counter and an 8N1 UART transmitter. Reads return data in the same cycle, as the single-cycle core requires; writes commit at the clock edge.

---
 rtl/dmem_map_pkg.sv | 24 ++
 rtl/uart_tx_fsm.sv | 75 +++++++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_map_pkg.sv
// Shared address-map constants and UART state type for the data-memory responder.
package dmem_map_pkg;

  // Word offsets of the MMIO registers inside the MMIO block
  localparam logic [3:0] MMIO_OFF_GPIO      = 4'h0;
  localparam logic [3:0] MMIO_OFF_UART_TX   = 4'h4;
  localparam logic [3:0] MMIO_OFF_UART_STAT = 4'h8;
  localparam logic [3:0] MMIO_OFF_CYCLE     = 4'hC;

  // UART_STATUS bit positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_OVF_BIT  = 1;

  // Number of low address bits decoded inside the MMIO block (16-byte region)
  localparam int MMIO_SPAN_W = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_fsm
  import dmem_map_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       r_state;
  uart_state_e       w_next;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_data;
  logic              w_baud_done;

  assign w_baud_done = (r_baud == BAUD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= UART_IDLE;
    else        r_state <= w_next;
  end

  // Baud and bit counters restart on every entry from IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_baud <= '0;
      r_bit  <= '0;
    end else if (r_state == UART_IDLE) begin
      r_baud <= '0;
      r_bit  <= '0;
    end else begin
      r_baud <= w_baud_done ? '0 : r_baud + 1'b1;
      if (r_state == UART_DATA && w_baud_done) r_bit <= r_bit + 3'd1;
    end
  end

  // Byte latch captures the payload when a frame is accepted
  always_ff @(posedge clk) begin
    if (r_state == UART_IDLE && start) r_data <= data;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      UART_IDLE:  if (start) w_next = UART_START;
      UART_START: if (w_baud_done) w_next = UART_DATA;
      UART_DATA:  if (w_baud_done && r_bit == 3'd7) w_next = UART_STOP;
      UART_STOP:  if (w_baud_done) w_next = UART_IDLE;
      default:    w_next = UART_IDLE;
    endcase
  end

  // Line level and busy flag decoded from the current state
  always_comb begin
    tx   = 1'b1;
    busy = (r_state != UART_IDLE);
    case (r_state)
      UART_START: tx = 1'b0;
      UART_DATA:  tx = r_data[r_bit];
      default:    tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the single-cycle core: RAM plus GPIO/UART/CYCLE MMIO.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int          RAM_WORDS    = 1024,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_read_en,
  input  logic        dmem_write_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        uart_tx,
  output logic [7:0]  gpio_out,
  output logic        bus_err
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]            r_ram [RAM_WORDS];
  logic [7:0]             r_gpio;
  logic [31:0]            r_cycle;
  logic                   r_ovf;
  logic                   r_bus_err;

  logic [IDX_W-1:0]       w_ram_idx;
  logic [MMIO_SPAN_W-1:0] w_off;
  logic                   w_aligned;
  logic                   w_ram_sel;
  logic                   w_mmio_sel;
  logic                   w_bad;
  logic                   w_wr_ram;
  logic                   w_wr_gpio;
  logic                   w_wr_tx;
  logic                   w_wr_stat;
  logic                   w_wr_cycle;
  logic                   w_uart_start;
  logic                   w_uart_busy;

  // Address decode; RAM wins if the MMIO window were ever placed inside it
  assign w_ram_idx  = dmem_addr[IDX_W+1:2];
  assign w_off      = dmem_addr[MMIO_SPAN_W-1:0];
  assign w_aligned  = (dmem_addr[1:0] == 2'b00);
  assign w_ram_sel  = w_aligned && (dmem_addr[31:IDX_W+2] == '0);
  assign w_mmio_sel = w_aligned && !w_ram_sel &&
                      (dmem_addr[31:MMIO_SPAN_W] == MMIO_BASE[31:MMIO_SPAN_W]);
  assign w_bad      = (dmem_read_en || dmem_write_en) && !(w_ram_sel || w_mmio_sel);

  assign w_wr_ram     = dmem_write_en && w_ram_sel;
  assign w_wr_gpio    = dmem_write_en && w_mmio_sel && (w_off == MMIO_OFF_GPIO);
  assign w_wr_tx      = dmem_write_en && w_mmio_sel && (w_off == MMIO_OFF_UART_TX);
  assign w_wr_stat    = dmem_write_en && w_mmio_sel && (w_off == MMIO_OFF_UART_STAT);
  assign w_wr_cycle   = dmem_write_en && w_mmio_sel && (w_off == MMIO_OFF_CYCLE);
  assign w_uart_start = w_wr_tx && !w_uart_busy;

  assign gpio_out = r_gpio;
  assign bus_err  = r_bus_err;

  uart_tx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_uart_start),
    .data (dmem_wdata[7:0]),
    .busy (w_uart_busy),
    .tx   (uart_tx)
  );

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[w_ram_idx] <= dmem_wdata;
  end

  // GPIO, sticky flags and the free-running cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gpio    <= '0;
      r_cycle   <= '0;
      r_ovf     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_wr_gpio) r_gpio <= dmem_wdata[7:0];
      r_cycle <= w_wr_cycle ? dmem_wdata : r_cycle + 32'd1;
      if (w_wr_tx && w_uart_busy)                  r_ovf <= 1'b1;
      else if (w_wr_stat && dmem_wdata[STAT_OVF_BIT]) r_ovf <= 1'b0;
      if (w_bad) r_bus_err <= 1'b1;
    end
  end

  // Same-cycle read mux; returns the value held before any write at this edge
  always_comb begin
    dmem_rdata = '0;
    if (dmem_read_en) begin
      if (w_ram_sel) begin
        dmem_rdata = r_ram[w_ram_idx];
      end else if (w_mmio_sel) begin
        case (w_off)
          MMIO_OFF_GPIO: dmem_rdata = {24'h0, r_gpio};
          MMIO_OFF_UART_STAT: begin
            dmem_rdata[STAT_BUSY_BIT] = w_uart_busy;
            dmem_rdata[STAT_OVF_BIT]  = r_ovf;
          end
          MMIO_OFF_CYCLE: dmem_rdata = r_cycle;
          default:        dmem_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 4-clock UART bit period.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          CPB  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_tx;
  logic [7:0]  gpio_out;
  logic        bus_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .RAM_WORDS   (1024),
    .CLKS_PER_BIT(CPB),
    .MMIO_BASE   (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_read_en (re),
    .dmem_write_en(we),
    .dmem_addr    (addr),
    .dmem_wdata   (wdata),
    .dmem_rdata   (rdata),
    .uart_tx      (uart_tx),
    .gpio_out     (gpio_out),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; addr = a; wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level per clock of one frame: start, 8 data LSB first, stop
  function automatic logic [39:0] frame(input logic [7:0] b);
    logic [39:0] v;
    for (int c = 0; c < 10 * CPB; c++) begin
      int k;
      k = c / CPB;
      if (k == 0)      v[c] = 1'b0;
      else if (k == 9) v[c] = 1'b1;
      else             v[c] = b[k-1];
    end
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] txv;
    int          busy_cnt;

    // Reset state
    rst_n = 1'b0;
    bus(0, 0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_uart_tx", 40'(uart_tx), 40'd1);
    chk("rst_gpio", 40'(gpio_out), 40'h0);
    chk("rst_bus_err", 40'(bus_err), 40'd0);
    bus(0, 0, 32'h10, 32'h0);
    #1 chk("rdata_no_read_en", 40'(rdata), 40'h0);
    bus(1, 0, BASE + 32'h8, 32'h0);
    #1 chk("rst_status", 40'(rdata), 40'h0);
    bus(1, 0, BASE + 32'hC, 32'h0);
    #1 chk("rst_cycle", 40'(rdata), 40'h0);
    rst_n = 1'b1;
    bus(0, 0, 32'h0, 32'h0);
    tick();

    // RAM write then read; simultaneous read/write returns pre-write value
    bus(0, 1, 32'h10, 32'hDEAD_BEEF);
    tick();
    bus(1, 0, 32'h10, 32'h0);
    #1 chk("ram_rd", 40'(rdata), 40'hDEAD_BEEF);
    bus(1, 1, 32'h10, 32'h1234_5678);
    #1 chk("ram_rw_old", 40'(rdata), 40'hDEAD_BEEF);
    tick();
    bus(1, 0, 32'h10, 32'h0);
    #1 chk("ram_rw_new", 40'(rdata), 40'h1234_5678);

    // GPIO
    bus(0, 1, BASE, 32'h0000_01A5);
    tick();
    bus(1, 0, BASE, 32'h0);
    #1 chk("gpio_out", 40'(gpio_out), 40'hA5);
    chk("gpio_rd", 40'(rdata), 40'hA5);
    chk("bus_err_clean", 40'(bus_err), 40'd0);

    // Misaligned and unmapped accesses
    bus(1, 1, BASE + 32'h2, 32'h0000_00FF);
    #1 chk("misaligned_rd", 40'(rdata), 40'h0);
    tick();
    bus(0, 0, 32'h0, 32'h0);
    #1 chk("misaligned_gpio_kept", 40'(gpio_out), 40'hA5);
    chk("bus_err_set", 40'(bus_err), 40'd1);
    bus(1, 0, 32'h2000_0000, 32'h0);
    #1 chk("unmapped_rd", 40'(rdata), 40'h0);
    tick();
    tick();
    bus(0, 0, 32'h0, 32'h0);
    #1 chk("bus_err_sticky", 40'(bus_err), 40'd1);

    // CYCLE load and wrap
    bus(0, 1, BASE + 32'hC, 32'hFFFF_FFFE);
    tick();
    bus(1, 0, BASE + 32'hC, 32'h0);
    #1 chk("cycle_load", 40'(rdata), 40'hFFFF_FFFE);
    tick();
    chk("cycle_inc", 40'(rdata), 40'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", 40'(rdata), 40'h0);

    // Frame 1: 0x55, busy watched through STATUS every cycle
    bus(0, 1, BASE + 32'h4, 32'h55);
    tick();
    busy_cnt = 0;
    txv = '0;
    for (int c = 0; c < 10 * CPB; c++) begin
      bus(1, 0, BASE + 32'h8, 32'h0);
      #1;
      txv[c] = uart_tx;
      if (rdata[0]) busy_cnt++;
      tick();
    end
    chk("frame1_tx", txv, frame(8'h55));
    chk("frame1_busy_cycles", 40'(busy_cnt), 40'd40);
    bus(1, 0, BASE + 32'h8, 32'h0);
    #1 chk("frame1_idle_status", 40'(rdata), 40'h0);
    chk("frame1_idle_tx", 40'(uart_tx), 40'd1);

    // Frame 2 accepted in the first idle cycle; overflow while busy
    bus(0, 1, BASE + 32'h4, 32'hA3);
    tick();
    txv = '0;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == 6)       bus(0, 1, BASE + 32'h4, 32'hFF);
      else if (c == 12) bus(0, 1, BASE + 32'h8, 32'h2);
      else              bus(1, 0, BASE + 32'h8, 32'h0);
      #1;
      txv[c] = uart_tx;
      if (c == 0)  chk("frame2_busy", 40'(rdata), 40'h1);
      if (c == 8)  chk("status_ovf", 40'(rdata), 40'h3);
      if (c == 14) chk("status_ovf_clr", 40'(rdata), 40'h1);
      tick();
    end
    chk("frame2_tx", txv, frame(8'hA3));

    // Frame 3 interrupted by reset during the DATA state
    bus(0, 1, BASE + 32'h4, 32'hF0);
    tick();
    bus(0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 6; c++) tick();
    bus(1, 0, BASE + 32'h8, 32'h0);
    #1 chk("pre_rst_busy", 40'(rdata), 40'h1);
    chk("pre_rst_tx_data0", 40'(uart_tx), 40'd0);
    rst_n = 1'b0;
    tick();
    chk("midrst_tx", 40'(uart_tx), 40'd1);
    chk("midrst_status", 40'(rdata), 40'h0);
    chk("midrst_gpio", 40'(gpio_out), 40'h0);
    chk("midrst_bus_err", 40'(bus_err), 40'd0);
    bus(1, 0, BASE + 32'hC, 32'h0);
    #1 chk("midrst_cycle", 40'(rdata), 40'h0);
    bus(1, 0, 32'h10, 32'h0);
    #1 chk("midrst_ram_kept", 40'(rdata), 40'h1234_5678);
    rst_n = 1'b1;
    bus(0, 0, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
